// File: rtl/clk_rst_ctrl.sv
// rtl/clk_rst_ctrl.sv - reset release, run/halt/step clock enable, divided ticks and cycle counter
module clk_rst_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 3,
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run_en,
    input  logic                    step_req,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    output logic                    sys_rst_n,
    output logic                    cpu_ce,
    output logic [NUM_CH-1:0]       ch_tick,
    output logic [CNT_W-1:0]        cycle_cnt,
    output logic [1:0]              state
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_HOLD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HOLD_W-1:0]      hold_q, hold_d;
    logic                   sys_rst_q, sys_rst_d;
    logic                   step_q;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic                   sync_rise;
    logic                   hold_last;
    logic                   step_fire;

    assign sync_d    = {sync_q[SYNC_STAGES-2:0], 1'b1};
    // Last synchroniser flop is about to capture its first 1
    assign sync_rise = sync_d[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1];
    assign hold_last = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: if (sync_rise) state_d = ST_HOLD;
            ST_HOLD:  if (hold_last) state_d = run_en ? ST_RUN : ST_HALT;
            ST_RUN:   if (!run_en)   state_d = ST_HALT;
            ST_HALT:  if (run_en)    state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        step_fire = (state_q == ST_HALT) & step_req & ~step_q;
        cpu_ce    = (state_q == ST_RUN) | step_fire;
    end

    always_comb begin
        hold_d    = (state_q == ST_HOLD) ? hold_q + HOLD_W'(1) : hold_q;
        sys_rst_d = sys_rst_q | ((state_q == ST_HOLD) & hold_last);
        cycle_d   = cpu_ce ? cycle_q + CNT_W'(1) : cycle_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            hold_q    <= '0;
            sys_rst_q <= 1'b0;
            step_q    <= 1'b0;
            cycle_q   <= '0;
        end else begin
            sync_q    <= sync_d;
            hold_q    <= hold_d;
            sys_rst_q <= sys_rst_d;
            step_q    <= step_req;
            cycle_q   <= cycle_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             tick;

        assign div = div_cfg[i*DIV_W +: DIV_W];

        // >= rather than == so a divisor lowered below the count wraps at once
        always_comb begin
            tick  = 1'b0;
            cnt_d = cnt_q;
            if (div == '0) begin
                cnt_d = '0;
            end else if (cpu_ce) begin
                tick  = (cnt_q >= div - DIV_W'(1));
                cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign ch_tick[i] = tick;
    end

    assign sys_rst_n = sys_rst_q;
    assign cycle_cnt = cycle_q;
    assign state     = state_q;

endmodule
